// File: rtl/spi_apb_regs_pkg.sv
// spi_apb_regs_pkg: register word offsets, field positions and RX FSM encoding (rev 1.0)
`default_nettype none

package spi_apb_regs_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_RXDATA = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  localparam int CTRL_SPI_EN   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CPOL     = 2;
  localparam int CTRL_CPHA     = 3;
  localparam int CTRL_FIRSTBIT = 4;
  localparam int CTRL_PSC_LSB  = 8;

  localparam int ST_TR_FLAG  = 0;
  localparam int ST_IRQ      = 1;
  localparam int ST_IRQ_PEND = 2;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_REQ  = 2'd1,
    RX_WAIT = 2'd2,
    RX_DONE = 2'd3
  } rx_state_e;

  function automatic logic is_mapped(input logic [2:0] idx);
    return (idx <= REG_STATUS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_apb_regs.sv
// spi_apb_regs: APB3 slave exposing spi_top control, TX/RX strobes and a latched IRQ (rev 1.0)
`default_nettype none

module spi_apb_regs
  import spi_apb_regs_pkg::*;
#(
  parameter int         ADDR_W  = 12,
  parameter int         RD_LAT  = 1,
  parameter logic [3:0] PSC_RST = 4'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              irq_en_o,
  output logic              spi_en_o,
  output logic              wr_txfifo_o,
  output logic              rd_rxfifo_o,
  output logic [7:0]        wrdata_o,
  output logic [3:0]        psc_o,
  output logic              cpol_o,
  output logic              cpha_o,
  output logic              firstbit_o,
  input  logic [7:0]        rddata_i,
  input  logic              tr_flag_i,
  input  logic              irq_i,
  output logic              irq_out_o
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic       spi_en_q, irq_en_q, cpol_q, cpha_q, firstbit_q;
  logic [3:0] psc_q;
  logic [7:0] wrdata_q, rx_q;
  logic       wr_txfifo_q, rd_rxfifo_q;
  logic       irq_q, irq_pend_q, irq_pend_d, irq_out_q;
  logic [1:0] cnt_q;
  rx_state_e  state_q;

  logic [2:0] w_idx;
  logic       w_access, w_wr, w_rx_rd, w_w1c;
  logic       unused_ok;

  assign unused_ok = ^{paddr_i[ADDR_W-1:5], paddr_i[1:0], pwdata_i[31:12]};

  assign w_idx    = paddr_i[4:2];
  assign w_access = psel_i & penable_i;
  assign w_wr     = w_access & pwrite_i;
  assign w_rx_rd  = w_access & ~pwrite_i & (w_idx == REG_RXDATA);
  assign w_w1c    = w_wr & (w_idx == REG_STATUS) & pwdata_i[ST_IRQ_PEND];

  // Only an RXDATA read stalls, and it is released by the RX_DONE state.
  assign pready_o  = (state_q == RX_DONE) | ~w_rx_rd;
  assign pslverr_o = w_access & pready_o & ~is_mapped(w_idx);

  always_comb begin
    prdata_o = '0;
    if (state_q == RX_DONE) begin
      prdata_o = {24'd0, rx_q};
    end else if (w_access && !pwrite_i) begin
      case (w_idx)
        REG_CTRL:   prdata_o = {20'd0, psc_q, 3'd0, firstbit_q, cpha_q, cpol_q, irq_en_q, spi_en_q};
        REG_STATUS: prdata_o = {29'd0, irq_pend_q, irq_i, tr_flag_i};
        default:    prdata_o = '0;
      endcase
    end
  end

  // A new rising edge beats a simultaneous write-1-to-clear.
  assign irq_pend_d = (irq_i & ~irq_q) | (irq_pend_q & ~w_w1c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_en_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      firstbit_q  <= 1'b1;
      psc_q       <= PSC_RST;
      wrdata_q    <= '0;
      wr_txfifo_q <= 1'b0;
      irq_q       <= 1'b0;
      irq_pend_q  <= 1'b0;
      irq_out_q   <= 1'b0;
    end else begin
      wr_txfifo_q <= 1'b0;
      if (w_wr && w_idx == REG_CTRL) begin
        spi_en_q   <= pwdata_i[CTRL_SPI_EN];
        irq_en_q   <= pwdata_i[CTRL_IRQ_EN];
        cpol_q     <= pwdata_i[CTRL_CPOL];
        cpha_q     <= pwdata_i[CTRL_CPHA];
        firstbit_q <= pwdata_i[CTRL_FIRSTBIT];
        psc_q      <= pwdata_i[CTRL_PSC_LSB+3:CTRL_PSC_LSB];
      end
      if (w_wr && w_idx == REG_TXDATA) begin
        wrdata_q    <= pwdata_i[7:0];
        wr_txfifo_q <= 1'b1;
      end
      irq_q      <= irq_i;
      irq_pend_q <= irq_pend_d;
      irq_out_q  <= irq_pend_q & irq_en_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      rd_rxfifo_q <= 1'b0;
    end else begin
      rd_rxfifo_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (w_rx_rd) begin
            state_q     <= RX_REQ;
            rd_rxfifo_q <= 1'b1;
          end
        end
        RX_REQ: begin
          state_q <= RX_WAIT;
          cnt_q   <= '0;
        end
        RX_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            rx_q    <= rddata_i;
            state_q <= RX_DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RX_DONE: state_q <= RX_IDLE;
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign spi_en_o    = spi_en_q;
  assign irq_en_o    = irq_en_q;
  assign cpol_o      = cpol_q;
  assign cpha_o      = cpha_q;
  assign firstbit_o  = firstbit_q;
  assign psc_o       = psc_q;
  assign wrdata_o    = wrdata_q;
  assign wr_txfifo_o = wr_txfifo_q;
  assign rd_rxfifo_o = rd_rxfifo_q;
  assign irq_out_o   = irq_out_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_apb_regs.sv
// tb_spi_apb_regs: vector table, directed corner cases and randomized APB traffic against a register model
`default_nettype none

module tb_spi_apb_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [7:0]  rddata = 8'h00;
  logic        tr_flag = 1'b0, irq = 1'b0;

  logic [31:0] prdata;
  logic        pready, pslverr, irq_en, spi_en, wr_txfifo, rd_rxfifo;
  logic [7:0]  wrdata;
  logic [3:0]  psc;
  logic        cpol, cpha, firstbit, irq_out;

  spi_apb_regs #(.ADDR_W(12), .RD_LAT(1), .PSC_RST(4'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .irq_en_o(irq_en), .spi_en_o(spi_en), .wr_txfifo_o(wr_txfifo), .rd_rxfifo_o(rd_rxfifo),
    .wrdata_o(wrdata), .psc_o(psc), .cpol_o(cpol), .cpha_o(cpha), .firstbit_o(firstbit),
    .rddata_i(rddata), .tr_flag_i(tr_flag), .irq_i(irq), .irq_out_o(irq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // spi_top stand-in: each pop presents the next byte one clock later
  logic [7:0] rx_src [256];
  int         pidx = 0;
  int         eidx = 0;
  logic [7:0] tx_seen[$];
  logic [7:0] tx_exp[$];

  always @(posedge clk) begin
    if (rd_rxfifo) begin
      rddata <= rx_src[pidx % 256];
      pidx   <= pidx + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && wr_txfifo) tx_seen.push_back(wrdata);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic irq_rise, output logic [31:0] rd, output logic err,
                      output int waits);
    bit done;
    done = 0; waits = 0; rd = '0; err = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    if (irq_rise) irq = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (pready) begin
        rd = prdata; err = pslverr; done = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: addr %h got no pready expected pready within 20 clks", addr);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t        vt [13];
  logic [31:0] rd, ctrl_m, wd;
  logic        err, pend_m, wr, ok;
  logic [2:0]  idx;
  logic [11:0] addr;
  int          waits, exp_w;

  initial begin
    for (int i = 0; i < 256; i++) rx_src[i] = 8'($urandom);
    rx_src[0] = 8'hA5;

    vt[0]  = '{1'b0, 12'h000, 32'h0,          32'h0000_0410, 1'b0, 0};
    vt[1]  = '{1'b0, 12'h00C, 32'h0,          32'h0000_0000, 1'b0, 0};
    vt[2]  = '{1'b1, 12'h000, 32'h0000_041A, 32'h0,          1'b0, 0};
    vt[3]  = '{1'b0, 12'h000, 32'h0,          32'h0000_041A, 1'b0, 0};
    vt[4]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0,          1'b0, 0};
    vt[5]  = '{1'b0, 12'h000, 32'h0,          32'h0000_0F1F, 1'b0, 0};
    vt[6]  = '{1'b0, 12'h004, 32'h0,          32'h0000_0000, 1'b0, 0};
    vt[7]  = '{1'b0, 12'h014, 32'h0,          32'h0000_0000, 1'b1, 0};
    vt[8]  = '{1'b1, 12'h018, 32'h0000_1234, 32'h0,          1'b1, 0};
    vt[9]  = '{1'b0, 12'h01C, 32'h0,          32'h0000_0000, 1'b1, 0};
    vt[10] = '{1'b1, 12'h008, 32'h0000_00FF, 32'h0,          1'b0, 0};
    vt[11] = '{1'b1, 12'h000, 32'h0000_041A, 32'h0,          1'b0, 0};
    vt[12] = '{1'b0, 12'h000, 32'h0,          32'h0000_041A, 1'b0, 0};

    idle(3);
    chk("rst_outs_in_reset", 32'({wr_txfifo, rd_rxfifo, irq_out, pslverr, pready}), 32'h1);
    rst_n = 1'b1;
    idle(1);
    chk("rst_ctrl_pins", 32'({spi_en, irq_en, cpol, cpha, firstbit, psc}), 32'({5'b00001, 4'd4}));
    chk("rst_wrdata", 32'(wrdata), 32'h0);

    for (int i = 0; i < 13; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wd, 1'b0, rd, err, waits);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(vt[i].exp_waits));
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end
    chk("ctrl_41a_pins", 32'({spi_en, irq_en, cpol, cpha, firstbit, psc}), 32'({5'b01011, 4'd4}));
    chk("no_pop_on_rx_write", 32'(pidx), 32'h0);
    xfer(1'b1, 12'h000, 32'h0000_041B, 1'b0, rd, err, waits);
    chk("ctrl_41b_spi_en", 32'(spi_en), 32'h1);

    tx_seen.delete();
    xfer(1'b1, 12'h004, 32'h59, 1'b0, rd, err, waits);
    xfer(1'b1, 12'h004, 32'h39, 1'b0, rd, err, waits);
    xfer(1'b1, 12'h004, 32'h93, 1'b0, rd, err, waits);
    idle(2);
    chk("tx_pulse_count", 32'(tx_seen.size()), 32'd3);
    if (tx_seen.size() == 3) begin
      chk("tx_byte0", 32'(tx_seen[0]), 32'h59);
      chk("tx_byte1", 32'(tx_seen[1]), 32'h39);
      chk("tx_byte2", 32'(tx_seen[2]), 32'h93);
    end
    chk("tx_wrdata_held", 32'(wrdata), 32'h93);
    tx_seen.delete();

    xfer(1'b0, 12'h008, 32'h0, 1'b0, rd, err, waits);
    chk("rx_data_a5", rd, 32'h0000_00A5);
    chk("rx_waits", 32'(waits), 32'd3);
    chk("rx_one_pop", 32'(pidx), 32'd1);
    eidx = 1;

    irq = 1'b1;
    idle(3);
    xfer(1'b0, 12'h00C, 32'h0, 1'b0, rd, err, waits);
    chk("irq_status", rd, 32'h6);
    chk("irq_out_set", 32'(irq_out), 32'h1);
    xfer(1'b1, 12'h00C, 32'h4, 1'b0, rd, err, waits);
    xfer(1'b0, 12'h00C, 32'h0, 1'b0, rd, err, waits);
    chk("irq_w1c_status", rd, 32'h2);
    idle(2);
    chk("irq_out_cleared", 32'(irq_out), 32'h0);
    irq = 1'b0; idle(1);
    irq = 1'b1; idle(2);
    irq = 1'b0; idle(1);
    xfer(1'b1, 12'h00C, 32'h4, 1'b1, rd, err, waits);
    xfer(1'b0, 12'h00C, 32'h0, 1'b0, rd, err, waits);
    chk("irq_set_beats_w1c", rd, 32'h6);
    idle(2);
    chk("irq_out_after_race", 32'(irq_out), 32'h1);
    irq = 1'b0; idle(1);
    xfer(1'b1, 12'h00C, 32'h4, 1'b0, rd, err, waits);

    // psel dropped after the first access cycle: the pop must still happen
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008;
    idle(1);
    penable = 1'b1;
    idle(1);
    psel = 1'b0; penable = 1'b0;
    idle(5);
    chk("rx_abort_pop", 32'(pidx), 32'(eidx + 1));
    eidx++;
    xfer(1'b0, 12'h008, 32'h0, 1'b0, rd, err, waits);
    chk("rx_after_abort", rd, 32'(rx_src[eidx % 256]));
    eidx++;

    ctrl_m = 32'h0000_041B; pend_m = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (!irq) pend_m = 1'b1;
        irq = ~irq;
        idle(1);
      end
      tr_flag = 1'($urandom_range(0, 1));
      idx  = 3'($urandom_range(0, 7));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      addr = {7'($urandom), idx, 2'($urandom)};
      exp_w = 0;
      if (wr) begin
        if (idx == 3'd0) ctrl_m = wd & 32'h0000_0F1F;
        if (idx == 3'd1) tx_exp.push_back(wd[7:0]);
        if (idx == 3'd3 && wd[2]) pend_m = 1'b0;
      end
      xfer(wr, addr, wd, 1'b0, rd, err, waits);
      if (!wr) begin
        case (idx)
          3'd0: chk("rnd_rd_ctrl", rd, ctrl_m);
          3'd1: chk("rnd_rd_tx", rd, 32'h0);
          3'd2: begin
            chk("rnd_rd_rx", rd, 32'(rx_src[eidx % 256]));
            eidx++;
            exp_w = 3;
          end
          3'd3: chk("rnd_rd_status", rd, 32'({pend_m, irq, tr_flag}));
          default: chk("rnd_rd_unmapped", rd, 32'h0);
        endcase
      end
      chk("rnd_err", 32'(err), 32'(idx >= 3'd4));
      chk("rnd_waits", 32'(waits), 32'(exp_w));
      if (i % 8 == 7) begin
        idle(2);
        chk("rnd_irq_out", 32'(irq_out), 32'(pend_m & ctrl_m[1]));
      end
    end
    idle(3);
    chk("rnd_tx_count", 32'(tx_seen.size()), 32'(tx_exp.size()));
    ok = (tx_seen.size() == tx_exp.size());
    for (int i = 0; i < tx_exp.size() && ok; i++) ok = (tx_seen[i] == tx_exp[i]);
    chk("rnd_tx_bytes", 32'(ok), 32'h1);
    chk("rnd_pop_count", 32'(pidx), 32'(eidx));

    // asynchronous reset while waiting for RX data
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008;
    idle(1);
    penable = 1'b1;
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rx_strobe", 32'(rd_rxfifo), 32'h0);
    chk("rst_mid_rx_ctrl", 32'({spi_en, irq_en, cpol, cpha, firstbit, psc}), 32'({5'b00001, 4'd4}));
    psel = 1'b0; penable = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("rst_mid_rx_popped", 32'(pidx), 32'(eidx + 1));
    eidx++;
    xfer(1'b0, 12'h000, 32'h0, 1'b0, rd, err, waits);
    chk("post_rst_ctrl", rd, 32'h0000_0410);
    xfer(1'b0, 12'h008, 32'h0, 1'b0, rd, err, waits);
    chk("post_rst_rx_data", rd, 32'(rx_src[eidx % 256]));
    chk("post_rst_rx_waits", 32'(waits), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
